split_data: RTL and testbench

Read-path width converter for the VDMA. It takes OSIZE-bit AXI read-data words and emits a stream of ISIZE-bit pixels. It is the inverse of the write-side pixel packer. Pixels are packed MSB-first and may straddle word boundaries; leftover bits of one word are combined with the head of the next. It sits between the AXI read-data FIFO and the video output/timing stage.

---
 rtl/split_data.sv | 80 ++++++++
 tb/tb_split_data.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_data.sv
// Read-path width converter: unpacks OSIZE-bit AXI read words into a stream of
// ISIZE-bit pixels packed MSB-first, carrying partial pixels across word boundaries.
module split_data #(
  parameter int ISIZE = 24,
  parameter int OSIZE = 256
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             ialign,
  input  logic             ivalid,
  output logic             iready,
  input  logic [OSIZE-1:0] idata,
  input  logic             ilast,
  output logic             ovalid,
  input  logic             oready,
  output logic [ISIZE-1:0] odata,
  output logic             olast
);

  localparam int BW = OSIZE + ISIZE;
  localparam int CW = $clog2(BW + 1);
  localparam logic [CW-1:0] ISZ  = CW'(ISIZE);
  localparam logic [CW-1:0] OSZ  = CW'(OSIZE);
  localparam logic [CW:0]   ISZ2 = (CW+1)'(2 * ISIZE);

  logic [BW-1:0] data_buf;
  logic [CW-1:0] bcnt;
  logic          lastf;

  logic [BW-1:0] base_buf;
  logic [BW-1:0] load_buf;
  logic [CW-1:0] base_cnt;
  logic          load;
  logic          pop;

  // Handshakes: a word transfers when ivalid && iready, a pixel when
  // ovalid && oready, both on the rising edge. iready and ovalid are
  // complementary, so a cycle either loads or pops, never both; ialign
  // forces iready and suppresses any pop in its cycle.
  assign iready = ialign || (bcnt < ISZ);
  assign ovalid = (bcnt >= ISZ);
  assign odata  = data_buf[BW-1 -: ISIZE];
  assign olast  = lastf && ovalid && ({1'b0, bcnt} < ISZ2);
  assign load   = ivalid && iready;
  assign pop    = ovalid && oready && !ialign;

  // ialign starts a fresh line, so the residual is treated as empty.
  always_comb begin
    base_cnt = ialign ? '0 : bcnt;
    base_buf = ialign ? '0 : (data_buf & ~({BW{1'b1}} >> bcnt));
    load_buf = base_buf | ({idata, {ISIZE{1'b0}}} >> base_cnt);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      data_buf <= '0;
      bcnt     <= '0;
      lastf    <= 1'b0;
    end else if (load) begin
      data_buf <= load_buf;
      bcnt     <= base_cnt + OSZ;
      lastf    <= ilast;
    end else if (ialign) begin
      data_buf <= '0;
      bcnt     <= '0;
      lastf    <= 1'b0;
    end else if (pop) begin
      if (olast) begin
        // Pad bits after the final full pixel of a line are dropped.
        data_buf <= '0;
        bcnt     <= '0;
        lastf    <= 1'b0;
      end else begin
        data_buf <= data_buf << ISIZE;
        bcnt     <= bcnt - ISZ;
      end
    end
  end

endmodule

// File: tb/tb_split_data.sv
// Bench for split_data: 24/256 instance for packing, ilast, backpressure,
// ialign and reset; 32/256 instance for the even-ratio case.
module tb_split_data;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         rst_n;
  logic         ialign, ivalid, ilast, iready, ovalid, oready, olast;
  logic [255:0] idata;
  logic [23:0]  odata;

  logic         b_ialign, b_ivalid, b_ilast, b_iready, b_ovalid, b_oready, b_olast;
  logic [255:0] b_idata;
  logic [31:0]  b_odata;

  split_data #(.ISIZE(24), .OSIZE(256)) dut_a (
    .clock(clock), .rst_n(rst_n), .ialign(ialign), .ivalid(ivalid), .iready(iready),
    .idata(idata), .ilast(ilast), .ovalid(ovalid), .oready(oready), .odata(odata),
    .olast(olast)
  );

  split_data #(.ISIZE(32), .OSIZE(256)) dut_b (
    .clock(clock), .rst_n(rst_n), .ialign(b_ialign), .ivalid(b_ivalid), .iready(b_iready),
    .idata(b_idata), .ilast(b_ilast), .ovalid(b_ovalid), .oready(b_oready), .odata(b_odata),
    .olast(b_olast)
  );

  int checks = 0;
  int passes = 0;

  logic [24:0] exp_q[$];
  logic [32:0] exp_b_q[$];
  int          pop_at[$];

  int   mode;
  logic oready_man;
  logic rnd_ready = 1'b1;
  int   stall_left = 0;
  int   cyc = 0;

  assign oready = (mode == 0) ? oready_man : (mode == 1) ? 1'b1 : rnd_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic fail_note(input string name);
    checks++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Reference packer: pixel k of the stream has value first+k, MSB-first.
  function automatic logic [255:0] pack(input int isz, input int first, input int widx);
    logic [255:0] w;
    int g, k, bp, v;
    for (int b = 0; b < 256; b++) begin
      g = widx * 256 + b;
      k = g / isz;
      bp = isz - 1 - (g % isz);
      v = first + k;
      w[255-b] = v[bp];
    end
    return w;
  endfunction

  task automatic push_a(input int first, input int n, input logic last);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(last && i == n - 1), 24'(first + i)});
  endtask

  task automatic push_b(input int first, input int n, input logic last);
    for (int i = 0; i < n; i++)
      exp_b_q.push_back({(last && i == n - 1), 32'(first + i)});
  endtask

  // Random backpressure: stalls of 1..5 cycles.
  always @(posedge clock) begin
    #1;
    if (stall_left > 0) begin
      rnd_ready = 1'b0;
      stall_left--;
    end else if ($urandom_range(0, 2) == 0) begin
      stall_left = $urandom_range(0, 4);
      rnd_ready = 1'b0;
    end else begin
      rnd_ready = 1'b1;
    end
  end

  logic        prev_stall = 1'b0;
  logic [23:0] prev_data;
  logic [24:0] e_a;

  always @(negedge clock) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(ovalid), 64'(1));
        check("stall_data", 64'(odata), 64'(prev_data));
      end
      if (ovalid && !oready && !ialign) check("stall_iready", 64'(iready), 64'(0));
      prev_stall = ovalid && !oready && !ialign;
      prev_data = odata;
      if (ovalid && oready && !ialign) begin
        pop_at.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL pixel_a: got %0h expected none", {olast, odata});
        end else begin
          e_a = exp_q.pop_front();
          check("pixel_a", 64'({olast, odata}), 64'(e_a));
        end
      end
    end
  end

  logic [32:0] e_b;
  always @(negedge clock) begin
    if (rst_n && b_ovalid && b_oready) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        $display("FAIL pixel_b: got %0h expected none", {b_olast, b_odata});
      end else begin
        e_b = exp_b_q.pop_front();
        check("pixel_b", 64'({b_olast, b_odata}), 64'(e_b));
      end
    end
  end

  // Drivers start and end at posedge+1.
  task automatic send_a(input logic [255:0] w, input logic last, input logic align);
    int n = 0;
    ivalid = 1'b1; idata = w; ilast = last; ialign = align;
    forever begin
      @(negedge clock);
      if (iready) break;
      n++;
      if (n > 300) begin
        fail_note("send_a");
        break;
      end
    end
    @(posedge clock); #1;
    ivalid = 1'b0; ilast = 1'b0; ialign = 1'b0;
  endtask

  task automatic send_b(input logic [255:0] w, input logic last);
    int n = 0;
    b_ivalid = 1'b1; b_idata = w; b_ilast = last;
    forever begin
      @(negedge clock);
      if (b_iready) break;
      n++;
      if (n > 300) begin
        fail_note("send_b");
        break;
      end
    end
    @(posedge clock); #1;
    b_ivalid = 1'b0; b_ilast = 1'b0;
  endtask

  task automatic pop_n(input int n);
    int got = 0;
    int guard = 0;
    oready_man = 1'b1;
    while (got < n) begin
      @(negedge clock);
      if (ovalid && oready) got++;
      guard++;
      if (guard > 300) begin
        fail_note("pop_n");
        break;
      end
    end
    @(posedge clock); #1;
    oready_man = 1'b0;
  endtask

  task automatic drain_a();
    int guard = 0;
    while (exp_q.size() != 0) begin
      @(negedge clock);
      guard++;
      if (guard > 1000) begin
        fail_note("drain_a");
        exp_q.delete();
      end
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic drain_b();
    int guard = 0;
    while (exp_b_q.size() != 0) begin
      @(negedge clock);
      guard++;
      if (guard > 1000) begin
        fail_note("drain_b");
        exp_b_q.delete();
      end
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  int base;

  initial begin
    rst_n = 1'b0; mode = 1; oready_man = 1'b0;
    ialign = 1'b0; ivalid = 1'b0; ilast = 1'b0; idata = '0;
    b_ialign = 1'b0; b_ivalid = 1'b0; b_ilast = 1'b0; b_idata = '0; b_oready = 1'b1;
    #12;
    check("rst_iready", 64'(iready), 64'(1));
    check("rst_ovalid", 64'(ovalid), 64'(0));
    check("rst_odata", 64'(odata), 64'(0));
    check("rst_olast", 64'(olast), 64'(0));
    check("rst_b_ovalid", 64'(b_ovalid), 64'(0));
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;

    // Packing 24/256 with oready high: 32 pixels, bubbles after 9, 20, 31.
    push_a(0, 32, 1'b0);
    base = pop_at.size();
    for (int j = 0; j < 3; j++) send_a(pack(24, 0, j), 1'b0, 1'b0);
    drain_a();
    check("bubble_after_9", 64'(pop_at[base+10] - pop_at[base+9]), 64'(2));
    check("bubble_after_20", 64'(pop_at[base+21] - pop_at[base+20]), 64'(2));
    check("span_32_pixels", 64'(pop_at[base+31] - pop_at[base]), 64'(33));
    check("wrap_iready", 64'(iready), 64'(1));
    check("wrap_ovalid", 64'(ovalid), 64'(0));

    // ilast on the second word: 21 pixels, olast only on pixel 20.
    push_a(300, 21, 1'b1);
    send_a(pack(24, 300, 0), 1'b0, 1'b0);
    send_a(pack(24, 300, 1), 1'b1, 1'b0);
    drain_a();
    check("ilast_iready", 64'(iready), 64'(1));
    check("ilast_ovalid", 64'(ovalid), 64'(0));

    // Random backpressure over a full 3-word wrap.
    mode = 2;
    push_a(1000, 32, 1'b1);
    for (int j = 0; j < 3; j++) send_a(pack(24, 1000, j), (j == 2), 1'b0);
    drain_a();
    mode = 1;

    // ialign after 4 pixels of a word: residual never reappears.
    mode = 0;
    push_a(400, 4, 1'b0);
    push_a(500, 10, 1'b1);
    send_a(pack(24, 400, 0), 1'b0, 1'b0);
    pop_n(4);
    send_a(pack(24, 500, 0), 1'b1, 1'b1);
    mode = 1;
    drain_a();
    check("align_iready", 64'(iready), 64'(1));
    check("align_ovalid", 64'(ovalid), 64'(0));

    // Asynchronous reset with 200 bits buffered.
    mode = 0;
    push_a(200, 13, 1'b0);
    send_a(pack(24, 200, 0), 1'b0, 1'b0);
    pop_n(10);
    send_a(pack(24, 200, 1), 1'b0, 1'b0);
    pop_n(3);
    check("pre_rst_ovalid", 64'(ovalid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_ovalid", 64'(ovalid), 64'(0));
    check("arst_iready", 64'(iready), 64'(1));
    check("arst_olast", 64'(olast), 64'(0));
    check("arst_odata", 64'(odata), 64'(0));
    @(negedge clock); rst_n = 1'b1;
    @(posedge clock); #1;
    push_a(50, 10, 1'b1);
    send_a(pack(24, 50, 0), 1'b1, 1'b0);
    @(negedge clock);
    check("latency_ovalid", 64'(ovalid), 64'(1));
    check("latency_odata", 64'(odata), 64'(50));
    @(posedge clock); #1;
    mode = 1;
    drain_a();

    // Even ratio 32/256: 8 pixels per word, olast on the final pixel.
    push_b(0, 24, 1'b1);
    for (int j = 0; j < 3; j++) send_b(pack(32, 0, j), (j == 2));
    drain_b();
    check("even_iready", 64'(b_iready), 64'(1));
    check("even_ovalid", 64'(b_ovalid), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
